// File: rtl/param_counter.sv
// Generic up/down event counter: programmable terminal value, prescaled steps,
// wrap or saturate at the range ends, with a one-cycle event pulse and a sticky flag.
module param_counter #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
    parameter int unsigned      PRESCALE  = 1,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter_out,
    output logic             terminal_count,
    output logic             wrap_pulse,
    output logic             overflow_sticky
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             pulse_q, pulse_d;
    logic             sticky_q, sticky_d;
    logic             step;
    logic             at_max;
    logic             at_zero;

    // ">=" keeps the counter in range even if something upstream misbehaves.
    assign at_max  = (count_q >= MAX_VALUE);
    assign at_zero = (count_q == '0);

    if (PRESCALE > 1) begin : g_prescale
        localparam int unsigned     PS_W    = $clog2(PRESCALE);
        localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

        logic [PS_W-1:0] ps_q, ps_d;

        always_comb begin
            ps_d = ps_q;
            if (clear || load) begin
                ps_d = '0;
            end else if (enable) begin
                ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                ps_q <= '0;
            end else begin
                ps_q <= ps_d;
            end
        end

        assign step = enable && (ps_q == PS_LAST);
    end else begin : g_no_prescale
        assign step = enable;
    end

    always_comb begin
        count_d  = count_q;
        pulse_d  = 1'b0;
        sticky_d = sticky_q;
        if (clear) begin
            count_d  = '0;
            sticky_d = 1'b0;
        end else if (load) begin
            count_d = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
        end else if (step) begin
            if (up_down) begin
                if (at_max) begin
                    pulse_d  = 1'b1;
                    sticky_d = 1'b1;
                    count_d  = SATURATE ? MAX_VALUE : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    pulse_d  = 1'b1;
                    sticky_d = 1'b1;
                    count_d  = SATURATE ? '0 : MAX_VALUE;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
        end
    end

    assign counter_out     = count_q;
    assign wrap_pulse      = pulse_q;
    assign overflow_sticky = sticky_q;
    assign terminal_count  = up_down ? (count_q == MAX_VALUE) : at_zero;

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter: four configurations share one stimulus bus,
// each scenario task checks the instance it targets.
module tb_param_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       up_down = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;

    logic [3:0] cnt_def, cnt_sat, cnt_w9, cnt_ps3;
    logic       tc_def, tc_sat, tc_w9, tc_ps3;
    logic       wp_def, wp_sat, wp_w9, wp_ps3;
    logic       ov_def, ov_sat, ov_w9, ov_ps3;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    param_counter u_def (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .counter_out(cnt_def), .terminal_count(tc_def),
        .wrap_pulse(wp_def), .overflow_sticky(ov_def)
    );

    param_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .PRESCALE(1), .SATURATE(1'b1)) u_sat (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .counter_out(cnt_sat), .terminal_count(tc_sat),
        .wrap_pulse(wp_sat), .overflow_sticky(ov_sat)
    );

    param_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .PRESCALE(1), .SATURATE(1'b0)) u_w9 (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .counter_out(cnt_w9), .terminal_count(tc_w9),
        .wrap_pulse(wp_w9), .overflow_sticky(ov_w9)
    );

    param_counter #(.WIDTH(4), .MAX_VALUE(4'd15), .PRESCALE(3), .SATURATE(1'b0)) u_ps3 (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .counter_out(cnt_ps3), .terminal_count(tc_ps3),
        .wrap_pulse(wp_ps3), .overflow_sticky(ov_ps3)
    );

    // Advance one clock; outputs are read 1 ns after the rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({cnt_def, wp_def, ov_def} !== 6'b0) begin
            bad++;
            $display("FAIL reset_async got cnt=%0d wp=%0b ov=%0b want 0/0/0", cnt_def, wp_def, ov_def);
        end
        tick;
        tick;
        reset = 1'b0;
        tick;
        total++;
        if ({cnt_def, cnt_ps3, wp_def, ov_def} !== 10'b0) begin
            bad++;
            $display("FAIL reset_idle got cnt=%0d ps3=%0d wp=%0b ov=%0b want 0", cnt_def, cnt_ps3, wp_def, ov_def);
        end
    endtask

    task automatic test_count_up;
        int exp;
        enable  = 1'b1;
        up_down = 1'b1;
        exp     = 0;
        for (int i = 1; i <= 19; i++) begin
            tick;
            exp = (exp + 1) % 16;
            total++;
            if (cnt_def !== 4'(exp)) begin
                bad++;
                $display("FAIL up_cnt step %0d got %0d want %0d", i, cnt_def, exp);
            end
            total++;
            if (wp_def !== (exp == 0)) begin
                bad++;
                $display("FAIL up_wrap_pulse step %0d got %0b want %0b", i, wp_def, exp == 0);
            end
            total++;
            if (ov_def !== (i >= 16)) begin
                bad++;
                $display("FAIL up_sticky step %0d got %0b want %0b", i, ov_def, i >= 16);
            end
            total++;
            if (tc_def !== (exp == 15)) begin
                bad++;
                $display("FAIL up_tc step %0d got %0b want %0b", i, tc_def, exp == 15);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_saturate;
        clear = 1'b1;
        tick;
        clear   = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick;
            total++;
            if (cnt_sat !== ((i >= 9) ? 4'd9 : 4'(i))) begin
                bad++;
                $display("FAIL sat_cnt step %0d got %0d want %0d", i, cnt_sat, (i >= 9) ? 9 : i);
            end
            total++;
            if (wp_sat !== (i >= 10)) begin
                bad++;
                $display("FAIL sat_pulse step %0d got %0b want %0b", i, wp_sat, i >= 10);
            end
            total++;
            if (tc_sat !== (i >= 9)) begin
                bad++;
                $display("FAIL sat_tc step %0d got %0b want %0b", i, tc_sat, i >= 9);
            end
            total++;
            if (ov_sat !== (i >= 10)) begin
                bad++;
                $display("FAIL sat_sticky step %0d got %0b want %0b", i, ov_sat, i >= 10);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_down_wrap_and_clamp;
        logic [3:0] seq[4] = '{4'd1, 4'd0, 4'd9, 4'd8};
        logic       pl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       tcx[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        load       = 1'b1;
        load_value = 4'd2;
        tick;
        load = 1'b0;
        total++;
        if (cnt_w9 !== 4'd2) begin
            bad++;
            $display("FAIL down_load got %0d want 2", cnt_w9);
        end
        up_down = 1'b0;
        enable  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            total++;
            if (cnt_w9 !== seq[i] || wp_w9 !== pl[i] || tc_w9 !== tcx[i]) begin
                bad++;
                $display("FAIL down_seq step %0d got cnt=%0d wp=%0b tc=%0b want cnt=%0d wp=%0b tc=%0b",
                         i, cnt_w9, wp_w9, tc_w9, seq[i], pl[i], tcx[i]);
            end
        end
        enable     = 1'b0;
        load       = 1'b1;
        load_value = 4'd13;
        tick;
        load = 1'b0;
        total++;
        if (cnt_w9 !== 4'd9 || wp_w9 !== 1'b0 || ov_w9 !== 1'b1) begin
            bad++;
            $display("FAIL load_clamp got cnt=%0d wp=%0b ov=%0b want 9/0/1", cnt_w9, wp_w9, ov_w9);
        end
    endtask

    task automatic test_prescale;
        logic en_pat[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] ex[5] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        clear  = 1'b1;
        enable = 1'b0;
        tick;
        clear   = 1'b0;
        up_down = 1'b1;
        enable  = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick;
            total++;
            if (cnt_ps3 !== 4'(i / 3)) begin
                bad++;
                $display("FAIL ps3_cnt cycle %0d got %0d want %0d", i, cnt_ps3, i / 3);
            end
        end
        for (int i = 0; i < 5; i++) begin
            enable = en_pat[i];
            tick;
            total++;
            if (cnt_ps3 !== ex[i] || wp_ps3 !== 1'b0) begin
                bad++;
                $display("FAIL ps3_gap cycle %0d got cnt=%0d wp=%0b want %0d/0", i, cnt_ps3, wp_ps3, ex[i]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_priority;
        load       = 1'b1;
        load_value = 4'd9;
        tick;
        load    = 1'b0;
        up_down = 1'b1;
        enable  = 1'b1;
        tick;
        enable     = 1'b0;
        load       = 1'b1;
        load_value = 4'd5;
        tick;
        load = 1'b0;
        total++;
        if (cnt_w9 !== 4'd5 || ov_w9 !== 1'b1) begin
            bad++;
            $display("FAIL prio_setup got cnt=%0d ov=%0b want 5/1", cnt_w9, ov_w9);
        end
        clear      = 1'b1;
        load       = 1'b1;
        enable     = 1'b1;
        load_value = 4'd7;
        tick;
        clear = 1'b0;
        total++;
        if (cnt_w9 !== 4'd0 || ov_w9 !== 1'b0 || wp_w9 !== 1'b0) begin
            bad++;
            $display("FAIL prio_clear got cnt=%0d ov=%0b wp=%0b want 0/0/0", cnt_w9, ov_w9, wp_w9);
        end
        load_value = 4'd3;
        tick;
        load = 1'b0;
        total++;
        if (cnt_w9 !== 4'd3) begin
            bad++;
            $display("FAIL prio_load_vs_step got %0d want 3", cnt_w9);
        end
        tick;
        total++;
        if (cnt_w9 !== 4'd4) begin
            bad++;
            $display("FAIL back_to_back_step got %0d want 4", cnt_w9);
        end
        enable = 1'b0;
    endtask

    task automatic test_async_reset;
        clear = 1'b1;
        tick;
        clear   = 1'b0;
        up_down = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 7; i++) tick;
        total++;
        if (cnt_def !== 4'd7 || cnt_ps3 !== 4'd2) begin
            bad++;
            $display("FAIL pre_reset got def=%0d ps3=%0d want 7/2", cnt_def, cnt_ps3);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (cnt_def !== 4'd0 || cnt_ps3 !== 4'd0 || ov_def !== 1'b0 || wp_def !== 1'b0) begin
            bad++;
            $display("FAIL mid_cycle_reset got def=%0d ps3=%0d ov=%0b wp=%0b want 0", cnt_def, cnt_ps3, ov_def, wp_def);
        end
        #1 reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick;
            total++;
            if (cnt_def !== 4'(i) || cnt_ps3 !== ((i == 3) ? 4'd1 : 4'd0)) begin
                bad++;
                $display("FAIL post_reset cycle %0d got def=%0d ps3=%0d want %0d/%0d",
                         i, cnt_def, cnt_ps3, i, (i == 3) ? 1 : 0);
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset;
        test_count_up;
        test_saturate;
        test_down_wrap_and_clamp;
        test_prescale;
        test_priority;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
